serial_adder: RTL and testbench

//   Bit-serial N-bit adder built around the 1-bit full adder (f_adder).

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/f_adder.sv | 19 +
 rtl/serial_adder.sv | 140 ++++++++++++++
 tb/tb_serial_adder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encodings and the
//   width of the completion pulse. Imported by serial_adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // DONE is a single-state pulse; the FSM is built around this being 1.
    localparam int DONE_PULSE_CYCLES = 1;

endpackage

// File: rtl/f_adder.sv
// f_adder
//   1-bit combinational full adder.
// Ports
//   ain, bin  operand bits
//   cin       carry in
//   cout      carry out
//   sum       sum bit
module f_adder (
    input  logic ain,
    input  logic bin,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = ain ^ bin ^ cin;
    assign cout = (ain & bin) | (cin & (ain ^ bin));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands and carry-in are latched on an
//   accepted start, then one bit pair per clock (LSB first) goes through a
//   single f_adder; the sum is shifted in from the MSB end so the LSB ends up
//   at bit 0 after WIDTH shifts. A one-cycle done pulse marks a valid result.
//   Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
// Ports
//   clk    clock, rising edge
//   rst    asynchronous reset, active-high
//   start  request, sampled only in IDLE
//   a, b   operands, sampled on the accepted start edge
//   cin    initial carry, sampled on the accepted start edge
//   busy   high while shifting
//   done   one-cycle result-valid pulse
//   sum    result, held until the next accepted start
//   cout   final carry out, held with sum
//   ovf    signed overflow (SERIAL_ADD_OVF_EN only), held with sum
//
// state   | meaning
// S_IDLE  | waiting for start; result registers hold last answer
// S_SHIFT | one bit pair added per clock, WIDTH clocks total
// S_DONE  | single-cycle done pulse, then back to idle
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
        $error("serial_adder: WIDTH must be in 2..32");
    end
    if (DONE_PULSE_CYCLES != 1) begin : g_pulse_chk
        $error("serial_adder: DONE state produces a one-cycle pulse only");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    f_adder u_fa (
        .ain  (a_sh[0]),
        .bin  (b_sh[0]),
        .cin  (carry),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            if (state_q == S_IDLE && start) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
                sum   <= '0;
                cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                ovf   <= 1'b0;
`endif
            end else if (state_q == S_SHIFT) begin
                sum   <= {fa_sum, sum[WIDTH-1:1]};
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                carry <= fa_cout;
                cnt   <= cnt + 1'b1;
                if (last_bit) begin
                    cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    // carry into the MSB differs from carry out of it
                    ovf  <= carry ^ fa_cout;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start, then wait for done within a bounded budget.
    // hold_start keeps start asserted (with a=0x11) through the whole operation.
    task automatic run_add(input string tag,
                           input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic vc, input logic hold_start,
                           input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf);
        int k;
        int busy_cycles;
        int done_seen;
        @(negedge clk);
        start = 1'b1; a = va; b = vb; cin = vc;
        @(posedge clk);            // E0
        #1;
        if (hold_start) a = 8'h11;
        else start = 1'b0;
        busy_cycles = 0;
        done_seen   = 0;
        k           = 0;
        if (busy) busy_cycles++;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (busy) busy_cycles++;
        end
        if (!done) begin
            chk({tag, "_done_timeout"}, 0, 1);
        end else begin
            done_seen++;
            chk({tag, "_latency"}, k, WIDTH);
            chk({tag, "_busy_cycles"}, busy_cycles, WIDTH);
            chk({tag, "_busy_at_done"}, busy, 0);
            chk({tag, "_sum"}, sum, exp_sum);
            chk({tag, "_cout"}, cout, exp_cout);
`ifdef SERIAL_ADD_OVF_EN
            chk({tag, "_ovf"}, ovf, exp_ovf);
`else
            if (exp_ovf === 1'bx) chk({tag, "_ovf_unused"}, 0, 1);
`endif
            @(posedge clk); #1;    // E_WIDTH+1: DONE -> IDLE, start ignored
            if (hold_start) start = 1'b0;
            if (done) done_seen++;
            chk({tag, "_done_count"}, done_seen, 1);
            chk({tag, "_busy_after"}, busy, 0);
            chk({tag, "_sum_held"}, sum, exp_sum);
            @(posedge clk); #1;
            chk({tag, "_idle_stays"}, busy, 0);
            chk({tag, "_sum_held2"}, sum, exp_sum);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_add("zero",     8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_add("ff_p1",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("7f_p1",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_add("5a_a5_c",  8'h5A, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        run_add("80_80",    8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        run_add("3c_42_c",  8'h3C, 8'h42, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0);

        // Reset mid-operation: abort on shift edge 4, no done pulse afterwards.
        @(negedge clk);
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        @(posedge clk); #1;        // E0
        start = 1'b0;
        repeat (4) @(posedge clk); // E1..E4
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        begin
            int dn;
            dn = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            @(negedge clk);
            rst = 1'b0;
            repeat (12) begin
                @(posedge clk); #1;
                if (done || busy) dn++;
            end
            chk("abort_no_done", dn, 0);
        end

        run_add("post_rst", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
